quad_decoder: RTL and testbench
===============================

Name: quad_decoder

Overview:
- Quadrature decoder that generates the up/down direction and count stream for the team's up/down counter.
- Takes two asynchronous encoder phases (A, B) and synchronises them.
- Decodes each legal Gray-code step into a direction and a one-cycle step pulse.
- Keeps its own wrapping position counter and flags illegal double transitions.

Parameters:
- CNT_W, 16: width of the position counter.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (legal range 2..4).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- quad_a  input  1  encoder phase A, asynchronous to clk
- quad_b  input  1  encoder phase B, asynchronous to clk
- clear  input  1  synchronous clear of count and err_cnt
- count  output  CNT_W  position counter
- up_down  output  1  direction of the last legal step; 1 = up, 0 = down
- step  output  1  one-cycle pulse per legal step
- err  output  1  one-cycle pulse per illegal transition
- err_cnt  output  ERR_W  saturating count of illegal transitions

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, up_down=1, step=0, err=0, err_cnt=0.
  - Synchroniser flops=0, prev_ab=00, FSM=FILL.
- Synchroniser: quad_a and quad_b each pass through SYNC_STAGES flops. ab_s = {a_sync, b_sync}.
- FSM states:
  - FILL: counts SYNC_STAGES clock edges after reset release. No step, no err, count holds. On the final FILL edge, prev_ab <= ab_s and the FSM moves to TRACK. This means no spurious step occurs if the inputs are non-zero at reset release.
  - TRACK: every edge, prev_ab <= ab_s, and the (prev_ab, ab_s) pair is decoded.
- Forward (up) sequence of {A,B}: 00->10->11->01->00. Each such pair gives count+1, up_down<=1, step=1.
- Reverse (down) sequence: 00->01->11->10->00. Each such pair gives count-1, up_down<=0, step=1.
- ab_s == prev_ab: no action; step=0, err=0.
- Both bits change (00<->11, 10<->01): err=1 for one cycle, err_cnt+1 saturating at 2^ERR_W-1. count and up_down are unchanged.
- Latency: an input change is reflected in count/step/up_down after SYNC_STAGES+1 rising edges, counting the first edge that samples the new level. Default is 3 edges.
- Arithmetic: count wraps modulo 2^CNT_W (0 - 1 = all ones; all ones + 1 = 0).
- step, err and up_down are registered outputs.
- clear=1 in TRACK:
  - count<=0 and err_cnt<=0, overriding any coincident increment or decrement.
  - step, err and up_down still reflect the decode of that cycle.
  - prev_ab still updates.
- clear during FILL: count and err_cnt are held at 0.
- Reset mid-operation: all state returns to reset values immediately and the FSM re-enters FILL.

Optional Feature:
- Macro: QUAD_INDEX_EN.
- Defined:
  - Adds input port quad_idx (1 bit, asynchronous), synchronised with SYNC_STAGES flops.
  - A synchronised rising edge of quad_idx in TRACK loads count<=0 on that cycle.
  - Priority is clear > index > step. On the index cycle, step and up_down still reflect the decode.
- Undefined: no quad_idx port, no index logic, and behaviour is exactly as above.

Decomposition:
- Package quad_pkg holds:
  - State enum with FILL and TRACK.
  - AB encoding localparams: AB_00, AB_10, AB_11, AB_01.
  - Default-width constants.
- Sub-module sync_ff: parameterised SYNC_STAGES single-bit synchroniser with active-low asynchronous reset to 0. It is instantiated for A, B and (when QUAD_INDEX_EN is defined) the index input.

Test Plan:
- Hold A=B=1 through reset release, wait 5 cycles -> step never pulses, err=0, count=0 (FILL suppression).
- Four full forward cycles (16 legal steps, 10 cycles apart) -> 16 step pulses, count=16 (0x0010), up_down=1, err_cnt=0. Also check that the first step appears exactly 3 edges after the first A change.
- From count=16, three reverse steps -> count=13, up_down=0 after the first reverse step. Then one reverse step from count=0 after clear -> count=0xFFFF.
- Force AB 00->11 in one cycle -> err pulses once, count unchanged, err_cnt=1. Repeat 300 times -> err_cnt saturates at 255.
- Assert clear on the same cycle as a forward step decode at count=5 -> count=0, step=1, up_down=1, err_cnt=0. Separately, pull reset low mid-sequence at count=7 -> all outputs return to reset values asynchronously and the FSM re-enters FILL.
- With QUAD_INDEX_EN defined: pulse quad_idx at count=9 -> count=0 three edges later. Index together with clear -> count=0. Index together with a step -> count=0, step=1.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg: shared state encoding, AB phase constants and default widths for quad_decoder
package quad_pkg;

    typedef enum logic {FILL, TRACK} state_t;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_01 = 2'b01;

    localparam int CNT_W_DEF = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int ERR_W_DEF = 8;

    // next {A,B} state in the forward (count up) Gray sequence
    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        return ab == AB_00 ? AB_10 :
               ab == AB_10 ? AB_11 :
               ab == AB_11 ? AB_01 : AB_00;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep single-bit synchroniser, async active-low reset to 0
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r <= '0;
        else r <= {r[STAGES-2:0], d};
    end

    assign q = r[STAGES-1];
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature decoder with wrapping position counter and illegal-transition counter; optional index input enabled by QUAD_INDEX_EN
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
`ifdef QUAD_INDEX_EN
    input  logic             quad_idx,
`endif
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             up_down,
    output logic             step,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);
    state_t state, state_d;
    logic [2:0] fill_cnt, fill_d;
    logic [1:0] prev_ab, prev_d, ab_s;
    logic a_s, b_s, up_ev, dn_ev, bad, idx_zero;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .reset(reset), .d(quad_a), .q(a_s));
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .reset(reset), .d(quad_b), .q(b_s));

    assign ab_s = {a_s, b_s};

`ifdef QUAD_INDEX_EN
    logic idx_s, idx_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_idx (.clk(clk), .reset(reset), .d(quad_idx), .q(idx_s));

    // delayed copy of the synchronised index for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idx_q <= 1'b0;
        else idx_q <= idx_s;
    end

    assign idx_zero = (state == TRACK) && idx_s && !idx_q;
`else
    assign idx_zero = 1'b0;
`endif

    // FSM state, fill counter and previous synchronised phase pair
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            fill_cnt <= '0;
            prev_ab <= AB_00;
        end else begin
            state <= state_d;
            fill_cnt <= fill_d;
            prev_ab <= prev_d;
        end
    end

    // FILL waits until the synchronisers hold real input before seeding prev_ab; TRACK decodes each pair
    always_comb begin
        state_d = state;
        fill_d = fill_cnt;
        prev_d = prev_ab;
        up_ev = 1'b0;
        dn_ev = 1'b0;
        bad = 1'b0;
        if (state == FILL) begin
            fill_d = fill_cnt + 3'd1;
            if (fill_cnt == 3'(SYNC_STAGES)) begin
                state_d = TRACK;
                prev_d = ab_s;
            end
        end else begin
            prev_d = ab_s;
            up_ev = ab_s == fwd_next(prev_ab);
            dn_ev = prev_ab == fwd_next(ab_s);
            bad = (ab_s ^ prev_ab) == 2'b11;
        end
    end

    // registered outputs and counters; clear beats index beats step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            up_down <= 1'b1;
            step <= 1'b0;
            err <= 1'b0;
            err_cnt <= '0;
        end else begin
            step <= up_ev | dn_ev;
            err <= bad;
            up_down <= (up_ev | dn_ev) ? up_ev : up_down;
            count <= (clear || idx_zero) ? '0 :
                     up_ev ? count + CNT_W'(1) :
                     dn_ev ? count - CNT_W'(1) : count;
            err_cnt <= clear ? '0 :
                       (bad && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;
        end
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed self-checking bench for quad_decoder (index tests when QUAD_INDEX_EN is defined)
module tb_quad_decoder;
    logic clk = 1'b0;
    logic reset, quad_a, quad_b, clear;
    logic [15:0] count;
    logic up_down, step, err;
    logic [7:0] err_cnt;
`ifdef QUAD_INDEX_EN
    logic quad_idx;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int step_seen = 0;
    int err_seen = 0;
    int pos;
    logic [1:0] seq [4];

    quad_decoder dut (
        .clk(clk),
        .reset(reset),
`ifdef QUAD_INDEX_EN
        .quad_idx(quad_idx),
`endif
        .quad_a(quad_a),
        .quad_b(quad_b),
        .clear(clear),
        .count(count),
        .up_down(up_down),
        .step(step),
        .err(err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // tally output pulses away from the active edge
    always @(negedge clk) begin
        if (step) step_seen++;
        if (err) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p);
        pos = p & 3;
        {quad_a, quad_b} = seq[pos];
    endtask

    task automatic fwd(input int n);
        for (int i = 0; i < n; i++) begin
            drive(pos + 1);
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic rev(input int n);
        for (int i = 0; i < n; i++) begin
            drive(pos + 3);
            repeat (10) @(negedge clk);
        end
    endtask

    initial begin
        int s0;
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        reset = 1'b0;
        clear = 1'b0;
`ifdef QUAD_INDEX_EN
        quad_idx = 1'b0;
`endif
        drive(2);
        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_up_down", 32'(up_down), 1);
        check("rst_step", 32'(step), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);

        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("fill_no_step", 32'(step_seen), 0);
        check("fill_no_err", 32'(err_seen), 0);
        check("fill_count", 32'(count), 0);

        drive(pos + 1);
        repeat (2) @(negedge clk);
        check("lat_early", 32'(step), 0);
        @(negedge clk);
        check("lat_step", 32'(step), 1);
        repeat (7) @(negedge clk);
        fwd(15);
        check("fwd_steps", 32'(step_seen), 16);
        check("fwd_count", 32'(count), 32'h10);
        check("fwd_up_down", 32'(up_down), 1);
        check("fwd_err_cnt", 32'(err_cnt), 0);

        rev(1);
        check("rev_up_down", 32'(up_down), 0);
        rev(2);
        check("rev_count", 32'(count), 13);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_count", 32'(count), 0);
        rev(1);
        check("wrap_count", 32'(count), 32'hffff);

        drive(pos + 2);
        repeat (10) @(negedge clk);
        check("err_pulse", 32'(err_seen), 1);
        check("err_count_hold", 32'(count), 32'hffff);
        check("err_cnt_1", 32'(err_cnt), 1);
        for (int i = 0; i < 299; i++) begin
            drive(pos + 2);
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("err_pulses", 32'(err_seen), 300);
        check("err_sat", 32'(err_cnt), 255);
        check("err_up_down", 32'(up_down), 0);

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        fwd(5);
        check("pre_clr_count", 32'(count), 5);
        drive(pos + 1);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_step_count", 32'(count), 0);
        check("clr_step_step", 32'(step), 1);
        check("clr_step_dir", 32'(up_down), 1);
        check("clr_step_err_cnt", 32'(err_cnt), 0);
        repeat (7) @(negedge clk);

        fwd(8);
        rev(1);
        check("pre_rst_count", 32'(count), 7);
        check("pre_rst_dir", 32'(up_down), 0);
        #2 reset = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_up_down", 32'(up_down), 1);
        check("arst_err_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        s0 = step_seen;
        repeat (6) @(negedge clk);
        check("refill_no_step", 32'(step_seen - s0), 0);
        check("refill_count", 32'(count), 0);
        fwd(1);
        check("refill_track", 32'(count), 1);

`ifdef QUAD_INDEX_EN
        fwd(8);
        check("pre_idx_count", 32'(count), 9);
        quad_idx = 1'b1;
        repeat (2) @(negedge clk);
        check("idx_early", 32'(count), 9);
        @(negedge clk);
        check("idx_zero", 32'(count), 0);
        quad_idx = 1'b0;
        repeat (5) @(negedge clk);

        fwd(2);
        quad_idx = 1'b1;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("idx_clr_count", 32'(count), 0);
        quad_idx = 1'b0;
        repeat (5) @(negedge clk);

        fwd(3);
        check("pre_idx_step", 32'(count), 3);
        drive(pos + 1);
        quad_idx = 1'b1;
        repeat (3) @(negedge clk);
        check("idx_step_count", 32'(count), 0);
        check("idx_step_step", 32'(step), 1);
        quad_idx = 1'b0;
        repeat (5) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
